audio_mix4: RTL and testbench

Time-multiplexed stereo mixer feeding the `left_in`/`right_in` ports of the audio output stage. On each sample strobe it captures CH signed mono sources and applies a per-channel left and right gain using one shared multiplier. It sums, scales and saturates the results to 16-bit signed, then holds them stable until the next strobe. The hold keeps the downstream low-pass filter and DACs fed with coherent, clip-safe samples.

---
 rtl/audio_mix4_if.sv | 29 ++
 rtl/audio_mix4.sv | 128 ++++++++++++
 tb/tb_audio_mix4.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/audio_mix4_if.sv
// audio_mix4_if: strobe, sources, gains and mixed-sample results of the stereo mixer.
interface audio_mix4_if #(
    parameter int CH = 4,
    parameter int GW = 8
);
    logic              sample_ce;
    logic [16*CH-1:0]  ch_in;
    logic [GW*CH-1:0]  gain_l;
    logic [GW*CH-1:0]  gain_r;
    logic              mute;
    logic              clr_clip;
    logic [15:0]       left_out;
    logic [15:0]       right_out;
    logic              out_valid;
    logic              busy;
    logic              overrun;
    logic              clip_l;
    logic              clip_r;

    modport master (
        output sample_ce, ch_in, gain_l, gain_r, mute, clr_clip,
        input  left_out, right_out, out_valid, busy, overrun, clip_l, clip_r
    );

    modport slave (
        input  sample_ce, ch_in, gain_l, gain_r, mute, clr_clip,
        output left_out, right_out, out_valid, busy, overrun, clip_l, clip_r
    );
endinterface

// File: rtl/audio_mix4.sv
// audio_mix4: time-multiplexed stereo mixer, one shared multiplier, saturating held outputs.
module audio_mix4 #(
    parameter int CH = 4,
    parameter int GW = 8
) (
    input logic         clk,
    input logic         rst_n,
    audio_mix4_if.slave bus
);
    localparam int KW = $clog2(2 * CH);
    localparam int PW = 17 + GW;
    localparam int AW = PW + $clog2(CH);
    localparam logic signed [AW-1:0] MAXV = AW'(32767);
    localparam logic signed [AW-1:0] MINV = AW'(-32768);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d, i;
    logic [16*CH-1:0]      ch_q, ch_d;
    logic [GW*CH-1:0]      gl_q, gl_d, gr_q, gr_d;
    logic signed [AW-1:0]  accl_q, accl_d, accr_q, accr_d;
    logic signed [AW-1:0]  prod_x, suml, sumr, scl, scr;
    logic signed [15:0]    s;
    logic signed [GW:0]    g;
    logic signed [PW-1:0]  prod;
    logic [15:0]           left_q, left_d, right_q, right_d, val_l, val_r;
    logic                  out_valid_q, out_valid_d, busy_q, busy_d, overrun_q, overrun_d;
    logic                  clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic                  sat_l, sat_r, last;

    // The final step's product is folded in combinationally so the outputs land on entry to OUT.
    always_comb begin
        i = k_q >> 1;
        s = ch_q[16*i +: 16];
        g = {1'b0, k_q[0] ? gr_q[GW*i +: GW] : gl_q[GW*i +: GW]};
        prod = s * g;
        prod_x = AW'(prod);
        suml = accl_q + (k_q[0] ? '0 : prod_x);
        sumr = accr_q + (k_q[0] ? prod_x : '0);
        scl = suml >>> (GW - 1);
        scr = sumr >>> (GW - 1);
        sat_l = scl > MAXV || scl < MINV;
        sat_r = scr > MAXV || scr < MINV;
        val_l = sat_l ? (scl[AW-1] ? 16'h8000 : 16'h7fff) : scl[15:0];
        val_r = sat_r ? (scr[AW-1] ? 16'h8000 : 16'h7fff) : scr[15:0];
        last = state_q == MAC && k_q == KW'(2 * CH - 1);
        state_d = state_q;
        k_d = k_q;
        ch_d = ch_q;
        gl_d = gl_q;
        gr_d = gr_q;
        accl_d = accl_q;
        accr_d = accr_q;
        left_d = left_q;
        right_d = right_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            IDLE: if (bus.sample_ce) begin
                state_d = MAC;
                ch_d = bus.ch_in;
                gl_d = bus.gain_l;
                gr_d = bus.gain_r;
                accl_d = '0;
                accr_d = '0;
                k_d = '0;
            end
            MAC: begin
                accl_d = suml;
                accr_d = sumr;
                k_d = k_q + 1'b1;
                if (last) begin
                    state_d = OUT;
                    left_d = bus.mute ? '0 : val_l;
                    right_d = bus.mute ? '0 : val_r;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        overrun_d = bus.sample_ce && state_q != IDLE;
        clip_l_d = (clip_l_q && !bus.clr_clip) || (last && sat_l);
        clip_r_d = (clip_r_q && !bus.clr_clip) || (last && sat_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q <= '0;
            ch_q <= '0;
            gl_q <= '0;
            gr_q <= '0;
            accl_q <= '0;
            accr_q <= '0;
            left_q <= '0;
            right_q <= '0;
            out_valid_q <= 1'b0;
            busy_q <= 1'b0;
            overrun_q <= 1'b0;
            clip_l_q <= 1'b0;
            clip_r_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            ch_q <= ch_d;
            gl_q <= gl_d;
            gr_q <= gr_d;
            accl_q <= accl_d;
            accr_q <= accr_d;
            left_q <= left_d;
            right_q <= right_d;
            out_valid_q <= out_valid_d;
            busy_q <= busy_d;
            overrun_q <= overrun_d;
            clip_l_q <= clip_l_d;
            clip_r_q <= clip_r_d;
        end
    end

    assign bus.left_out = left_q;
    assign bus.right_out = right_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy = busy_q;
    assign bus.overrun = overrun_q;
    assign bus.clip_l = clip_l_q;
    assign bus.clip_r = clip_r_q;
endmodule

// File: tb/tb_audio_mix4.sv
// tb_audio_mix4: directed bench for audio_mix4 with an expected-sample queue and a behavioural mix model.
module tb_audio_mix4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] sb[$];

    audio_mix4_if #(.CH(4), .GW(8)) bus ();
    audio_mix4 #(.CH(4), .GW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
    endfunction

    // Reference: full-precision sums, floor divide by unity gain, then clamp.
    function automatic logic [31:0] model(input logic [63:0] c, input logic [31:0] gl,
                                          input logic [31:0] gr, input logic m);
        longint al = 0;
        longint ar = 0;
        for (int n = 0; n < 4; n++) begin
            al += longint'($signed(c[16*n +: 16])) * longint'({1'b0, gl[8*n +: 8]});
            ar += longint'($signed(c[16*n +: 16])) * longint'({1'b0, gr[8*n +: 8]});
        end
        al = al >>> 7;
        ar = ar >>> 7;
        return m ? 32'h0 : {sat16(al), sat16(ar)};
    endfunction

    task automatic chk_idle_regs(input string tag);
        chk({tag, "_left"}, bus.left_out, 0);
        chk({tag, "_right"}, bus.right_out, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
        chk({tag, "_clip_l"}, bus.clip_l, 0);
        chk({tag, "_clip_r"}, bus.clip_r, 0);
    endtask

    task automatic run_mix(input string tag, input logic [63:0] c, input logic [31:0] gl,
                           input logic [31:0] gr);
        int cnt;
        logic [31:0] e;
        sb.push_back(model(c, gl, gr, bus.mute));
        bus.ch_in = c;
        bus.gain_l = gl;
        bus.gain_r = gr;
        bus.sample_ce = 1'b1;
        @(posedge clk); #1;
        bus.sample_ce = 1'b0;
        bus.ch_in = {$urandom, $urandom};
        bus.gain_l = $urandom;
        bus.gain_r = $urandom;
        chk({tag, "_busy"}, bus.busy, 1);
        cnt = 1;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, cnt, 9);
        e = sb.pop_front();
        chk({tag, "_left"}, bus.left_out, e[31:16]);
        chk({tag, "_right"}, bus.right_out, e[15:0]);
        @(posedge clk); #1;
        chk({tag, "_valid_pulse"}, bus.out_valid, 0);
        chk({tag, "_busy_done"}, bus.busy, 0);
    endtask

    task automatic pulse_clr();
        bus.clr_clip = 1'b1;
        @(posedge clk); #1;
        bus.clr_clip = 1'b0;
    endtask

    initial begin
        int ov_cnt, ov_at, vc, vat, bad, hv;
        logic [31:0] e;
        bus.sample_ce = 1'b0;
        bus.ch_in = '0;
        bus.gain_l = '0;
        bus.gain_r = '0;
        bus.mute = 1'b0;
        bus.clr_clip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_regs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_mix("unity", 64'h0000_0000_0000_1234, 32'h0000_0080, 32'h0);

        run_mix("possat", 64'h7fff_7fff_7fff_7fff, 32'hffff_ffff, 32'hffff_ffff);
        chk("possat_clip_l", bus.clip_l, 1);
        chk("possat_clip_r", bus.clip_r, 1);
        run_mix("zerogain", 64'h7fff_7fff_7fff_7fff, 32'h0, 32'h0);
        chk("sticky_clip_l", bus.clip_l, 1);
        chk("sticky_clip_r", bus.clip_r, 1);
        pulse_clr();
        chk("clr_clip_l", bus.clip_l, 0);
        chk("clr_clip_r", bus.clip_r, 0);

        run_mix("negsat", 64'h0000_0000_0000_8000, 32'h0, 32'h0000_00ff);
        chk("negsat_clip_r", bus.clip_r, 1);
        chk("negsat_clip_l", bus.clip_l, 0);
        pulse_clr();
        run_mix("floor", 64'h0000_0000_0000_ffff, 32'h0000_0040, 32'h0);
        chk("floor_clip_l", bus.clip_l, 0);

        // Second strobe three cycles in, carrying different samples that must be ignored.
        sb.push_back(model(64'h0000_0000_0200_1000, 32'h0000_0080, 32'h0000_8000, 1'b0));
        bus.ch_in = 64'h0000_0000_0200_1000;
        bus.gain_l = 32'h0000_0080;
        bus.gain_r = 32'h0000_8000;
        bus.sample_ce = 1'b1;
        @(posedge clk); #1;
        bus.sample_ce = 1'b0;
        ov_cnt = 0; ov_at = 0; vc = 0; vat = 0;
        for (int c = 1; c <= 25; c++) begin
            if (bus.overrun) begin ov_cnt++; ov_at = c; end
            if (bus.out_valid) begin
                vc++;
                vat = c;
                if (vc == 1) begin
                    e = sb.pop_front();
                    chk("overrun_left", bus.left_out, e[31:16]);
                    chk("overrun_right", bus.right_out, e[15:0]);
                end
            end
            bus.sample_ce = (c == 3);
            if (c == 3) bus.ch_in = 64'h7fff_7fff_7fff_7fff;
            @(posedge clk); #1;
        end
        chk("overrun_count", ov_cnt, 1);
        chk("overrun_cycle", ov_at, 4);
        chk("overrun_valid_count", vc, 1);
        chk("overrun_valid_cycle", vat, 9);

        bus.mute = 1'b1;
        run_mix("mute", 64'h1111_2222_3333_4444, 32'h8080_8080, 32'h8080_8080);
        bus.mute = 1'b0;
        bad = 0; hv = 0;
        for (int c = 0; c < 100; c++) begin
            bus.ch_in = {$urandom, $urandom};
            @(posedge clk); #1;
            if (bus.left_out != 0 || bus.right_out != 0) bad++;
            if (bus.out_valid) hv++;
        end
        chk("hold_nonzero_cycles", bad, 0);
        chk("hold_valid_count", hv, 0);

        run_mix("presat", 64'h7fff_7fff_7fff_7fff, 32'hffff_ffff, 32'hffff_ffff);
        bus.ch_in = 64'h4000_4000_4000_4000;
        bus.gain_l = 32'hffff_ffff;
        bus.gain_r = 32'hffff_ffff;
        bus.sample_ce = 1'b1;
        @(posedge clk); #1;
        bus.sample_ce = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk_idle_regs("midreset");
        repeat (2) @(posedge clk);
        #1;
        chk_idle_regs("midreset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_mix("postreset", 64'h0000_0000_0000_0100, 32'h0000_0080, 32'h0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
